// File: rtl/uart_mc.sv
// uart_mc: full-duplex UART with 16x oversampled receiver, show-ahead FIFOs and sticky error flags.
// Define UART_PARITY_EN to insert/check one parity bit (even, or odd when PARITY_ODD=1).

module uart_mc_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // a full FIFO refuses a push even when a pop happens in the same cycle
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_mc #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 460_800,
  parameter int DATA_BITS  = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          rx,
  input  logic [DATA_BITS-1:0]          write_tx_data,
  input  logic                          enable_tx_write,
  input  logic                          enable_rx_read,
  input  logic                          clear_errors,
  output logic [DATA_BITS-1:0]          read_rx_data,
  output logic                          tx,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic                          tx_empty,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic                          frame_error,
  output logic                          overrun,
  output logic                          parity_error
);
  localparam int DIV_RAW = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIVW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW      = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT   = IW'(DATA_BITS - 1);
  localparam logic [4:0]    STOP_TICKS = 5'(16 * STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  logic [DIVW-1:0] div_cnt;
  logic            tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= DIVW'(DIV - 1);
    else           div_cnt <= div_cnt - 1'b1;
  end

  logic rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  // ---------------- receiver ----------------
  state_t                 rx_state;
  logic [3:0]             rx_cnt;
  logic [IW-1:0]          rx_idx;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_stop_tick, rx_push, frame_evt, overrun_evt;

  assign rx_stop_tick = enable && tick && (rx_state == STOP) && (rx_cnt == 4'd0);
  assign rx_push      = rx_stop_tick && rx_sync && !rx_full;
  assign frame_evt    = rx_stop_tick && !rx_sync;
  assign overrun_evt  = rx_stop_tick && rx_sync && rx_full;

`ifdef UART_PARITY_EN
  logic rx_par_bad;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else if (!enable) begin
      rx_state <= IDLE;
    end else if (tick) begin
      case (rx_state)
        IDLE: if (!rx_sync) begin
          rx_state <= START;
          rx_cnt   <= 4'd7;
        end
        START: if (rx_cnt != 4'd0) rx_cnt <= rx_cnt - 1'b1;
          else if (rx_sync) rx_state <= IDLE;
          else begin
            rx_state <= DATA;
            rx_cnt   <= 4'd15;
            rx_idx   <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
          end
        DATA: if (rx_cnt != 4'd0) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= 4'd15;
            rx_idx   <= rx_idx + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_idx == LAST_BIT) rx_state <= PARITY;
`else
            if (rx_idx == LAST_BIT) rx_state <= STOP;
`endif
          end
`ifdef UART_PARITY_EN
        PARITY: if (rx_cnt != 4'd0) rx_cnt <= rx_cnt - 1'b1;
          else begin
            rx_par_bad <= (rx_sync != parity_of(rx_shift));
            rx_state   <= STOP;
            rx_cnt     <= 4'd15;
          end
`endif
        STOP: if (rx_cnt != 4'd0) rx_cnt <= rx_cnt - 1'b1;
          else rx_state <= IDLE;
        default: rx_state <= IDLE;
      endcase
    end
  end

  // an error event in the same cycle as clear_errors leaves the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_evt)         frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
      if (overrun_evt)       overrun <= 1'b1;
      else if (clear_errors) overrun <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                            parity_error <= 1'b0;
    else if (rx_stop_tick && rx_par_bad)  parity_error <= 1'b1;
    else if (clear_errors)                parity_error <= 1'b0;
  end
`else
  logic unused_cfg;
  assign unused_cfg   = (PARITY_ODD != 0);
  assign parity_error = 1'b0;
`endif

  uart_mc_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (enable_rx_read),
    .head      (read_rx_data),
    .empty     (rx_empty),
    .full      (rx_full),
    .count     (rx_count)
  );

  // ---------------- transmitter ----------------
  state_t                 tx_state;
  logic [4:0]             tx_cnt;
  logic [IW-1:0]          tx_idx;
  logic [DATA_BITS-1:0]   tx_shift;
  logic [DATA_BITS-1:0]   tx_head;
  logic                   tx_load;
`ifdef UART_PARITY_EN
  logic                   tx_par;
`endif

  // loading from the last stop tick gives back-to-back frames with no idle gap
  assign tx_load = enable && tick && !tx_empty &&
                   ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == 5'd0)));

  uart_mc_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (enable_tx_write),
    .push_data (write_tx_data),
    .pop       (tx_load),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full),
    .count     (tx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_shift <= tx_head;
`ifdef UART_PARITY_EN
      tx_par   <= parity_of(tx_head);
`endif
      tx       <= 1'b0;
      tx_busy  <= 1'b1;
      tx_state <= START;
      tx_cnt   <= 5'd15;
    end else if (tick) begin
      case (tx_state)
        IDLE: ;
        START: if (tx_cnt != 5'd0) tx_cnt <= tx_cnt - 1'b1;
          else begin
            tx       <= tx_shift[0];
            tx_state <= DATA;
            tx_cnt   <= 5'd15;
            tx_idx   <= '0;
          end
        DATA: if (tx_cnt != 5'd0) tx_cnt <= tx_cnt - 1'b1;
          else if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx       <= tx_par;
            tx_state <= PARITY;
            tx_cnt   <= 5'd15;
`else
            tx       <= 1'b1;
            tx_state <= STOP;
            tx_cnt   <= STOP_TICKS;
`endif
          end else begin
            tx       <= tx_shift[1];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= tx_idx + 1'b1;
            tx_cnt   <= 5'd15;
          end
`ifdef UART_PARITY_EN
        PARITY: if (tx_cnt != 5'd0) tx_cnt <= tx_cnt - 1'b1;
          else begin
            tx       <= 1'b1;
            tx_state <= STOP;
            tx_cnt   <= STOP_TICKS;
          end
`endif
        STOP: if (tx_cnt != 5'd0) tx_cnt <= tx_cnt - 1'b1;
          else begin
            tx_state <= IDLE;
            tx_busy  <= 1'b0;
          end
        default: tx_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mc.sv
// Directed bench for uart_mc: loopback, FIFO limits, back-to-back TX, RX errors, glitch, reset abort.
module tb_uart_mc;
  localparam int DB = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = 16 * NBITS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          rx_drv = 1'b1;
  logic          loop = 1'b0;
  logic          rx_line;
  logic [DB-1:0] write_tx_data = '0;
  logic          enable_tx_write = 1'b0;
  logic          enable_rx_read = 1'b0;
  logic          clear_errors = 1'b0;
  logic [DB-1:0] read_rx_data;
  logic          tx, rx_empty, rx_full, tx_empty, tx_full, tx_busy;
  logic [2:0]    rx_count, tx_count;
  logic          frame_error, overrun, parity_error;

  int checks = 0;
  int failures = 0;

  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_mc #(
    .CLOCK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(DB),
    .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx_line),
    .write_tx_data(write_tx_data), .enable_tx_write(enable_tx_write),
    .enable_rx_read(enable_rx_read), .clear_errors(clear_errors),
    .read_rx_data(read_rx_data), .tx(tx),
    .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_count(rx_count), .tx_count(tx_count), .tx_busy(tx_busy),
    .frame_error(frame_error), .overrun(overrun), .parity_error(parity_error)
  );

  typedef struct {
    logic [7:0] data;
    int         cnt;
    logic       full;
    logic       empty;
  } txv_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    int         cnt;
    logic       fe;
    logic       ov;
    logic       full;
  } rxv_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic even_par(input logic [DB-1:0] d);
    return ^d;
  endfunction

  task automatic push(input logic [DB-1:0] d);
    write_tx_data   = d;
    enable_tx_write = 1'b1;
    tick(1);
    enable_tx_write = 1'b0;
  endtask

  task automatic pop();
    enable_rx_read = 1'b1;
    tick(1);
    enable_rx_read = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
    rx_drv = 1'b0;
    tick(16);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      tick(16);
    end
`ifdef UART_PARITY_EN
    rx_drv = par;
    tick(16);
`endif
    rx_drv = stop;
    tick(16);
    rx_drv = 1'b1;
    tick(24);
  endtask

  initial begin
    txv_t            txv [5];
    rxv_t            rxv [6];
    logic [NBITS-1:0] exp_bits;
    logic [DB-1:0]   lb_data;
    int              lat;
    int              off;

    txv[0] = '{8'h01, 1, 1'b0, 1'b0};
    txv[1] = '{8'h02, 2, 1'b0, 1'b0};
    txv[2] = '{8'h03, 3, 1'b0, 1'b0};
    txv[3] = '{8'h04, 4, 1'b1, 1'b0};
    txv[4] = '{8'h05, 4, 1'b1, 1'b0};

    rxv[0] = '{8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    rxv[1] = '{8'h11, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    rxv[2] = '{8'h22, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    rxv[3] = '{8'h33, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    rxv[4] = '{8'h44, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    rxv[5] = '{8'h55, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_tx", tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_full", rx_full, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_read_rx_data", read_rx_data, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_error", parity_error, 0);

    // loopback of one word
    enable = 1'b1;
    loop   = 1'b1;
    tick(2);
    lb_data = 8'hA5;
    exp_bits = '0;
    for (int i = 0; i < DB; i++) exp_bits[1+i] = lb_data[i];
`ifdef UART_PARITY_EN
    exp_bits[DB+1] = even_par(lb_data);
`endif
    exp_bits[NBITS-1] = 1'b1;
    push(lb_data);
    lat = 0;
    while (tx === 1'b1 && lat < 4) begin
      tick(1);
      lat++;
    end
    check("lb_start_latency_ok", (tx === 1'b0 && lat <= 2) ? 1 : 0, 1);
    tick(8);
    for (int k = 0; k < NBITS; k++) begin
      check($sformatf("lb_bit%0d", k), tx, exp_bits[k]);
      check($sformatf("lb_busy%0d", k), tx_busy, 1);
      tick(16);
    end
    check("lb_busy_end", tx_busy, 0);
    check("lb_rx_count", rx_count, 1);
    check("lb_rx_empty", rx_empty, 0);
    check("lb_rx_data", read_rx_data, 8'hA5);
    pop();
    check("lb_rx_empty_after_pop", rx_empty, 1);

    // fill TX FIFO while held, then release for back-to-back frames
    enable = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      push(txv[i].data);
      check($sformatf("txf_count%0d", i), tx_count, txv[i].cnt);
      check($sformatf("txf_full%0d", i), tx_full, txv[i].full);
      check($sformatf("txf_empty%0d", i), tx_empty, txv[i].empty);
    end
    check("txf_held_idle", tx, 1);
    enable = 1'b1;
    tick(1);
    check("b2b_start0", tx, 0);
    check("b2b_count_after_load", tx_count, 3);
    off = 0;
    for (int k = 1; k < 4; k++) begin
      tick(FRAME * k - 1 - off);
      check($sformatf("b2b_stop%0d", k), tx, 1);
      tick(1);
      check($sformatf("b2b_start%0d", k), tx, 0);
      off = FRAME * k;
    end
    tick(FRAME + 20);
    check("b2b_busy_end", tx_busy, 0);
    check("b2b_tx_empty", tx_empty, 1);
    check("b2b_rx_count", rx_count, 4);
    check("b2b_rx_full", rx_full, 1);
    check("b2b_overrun", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_rx_data%0d", i), read_rx_data, i + 1);
      pop();
    end
    check("b2b_rx_empty", rx_empty, 1);

    // short low pulse on idle line
    loop   = 1'b0;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(40);
    check("glitch_rx_count", rx_count, 0);
    check("glitch_rx_empty", rx_empty, 1);
    check("glitch_frame_error", frame_error, 0);
    check("glitch_overrun", overrun, 0);

    // RX frames: frame error, fill, overrun
    for (int i = 0; i < 6; i++) begin
      if (rxv[i].clr) pulse_clear();
      send_frame(rxv[i].data, even_par(rxv[i].data), rxv[i].stop);
      check($sformatf("rxt_count%0d", i), rx_count, rxv[i].cnt);
      check($sformatf("rxt_frame_error%0d", i), frame_error, rxv[i].fe);
      check($sformatf("rxt_overrun%0d", i), overrun, rxv[i].ov);
      check($sformatf("rxt_full%0d", i), rx_full, rxv[i].full);
    end
    for (int i = 1; i < 5; i++) begin
      check($sformatf("rxt_data%0d", i), read_rx_data, rxv[i].data);
      pop();
    end
    check("rxt_empty_after_pops", rx_empty, 1);
    pulse_clear();
    check("rxt_overrun_cleared", overrun, 0);
    check("rxt_frame_error_clear", frame_error, 0);

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_flag", parity_error, 1);
    check("par_bad_count", rx_count, 1);
    check("par_bad_data", read_rx_data, 8'h07);
    pop();
    pulse_clear();
    check("par_cleared", parity_error, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_good_flag", parity_error, 0);
    check("par_good_data", read_rx_data, 8'h07);
    pop();
`endif

    // reset in the middle of a transmit frame
    push(8'h00);
    tick(20);
    check("rstmid_pre_tx", tx, 0);
    check("rstmid_pre_busy", tx_busy, 1);
    reset = 1'b1;
    tick(1);
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", tx_busy, 0);
    check("rstmid_tx_empty", tx_empty, 1);
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_mc.md
# uart_mc

Parametrised successor of the 16-bit UART: a full-duplex serial port with configurable data width, stop bits, and FIFO depth. It adds an oversampling receiver with glitch rejection, sticky frame and overrun error flags, FIFO occupancy counts, and optional parity. It sits between the board rx/tx pins and the processing core, and is driven by the core through push/pop strobes on two internal FIFOs.

## Interface
Parameters:
- CLOCK_RATE, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 460_800: line rate in bit/s.
- DATA_BITS, 16: payload width, 5..16.
- STOP_BITS, 1: transmitted stop bits, 1 or 2. Receiver always checks exactly one.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd. Used only with UART_PARITY_EN.

Ports:
- clk, in, 1: single clock. Reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high; clears FSMs, FIFOs, and flags.
- enable, in, 1: run control.
- rx, in, 1: asynchronous serial input.
- write_tx_data, in, DATA_BITS: word to push into the TX FIFO.
- enable_tx_write, in, 1: push strobe.
- enable_rx_read, in, 1: pop strobe.
- clear_errors, in, 1: clears the sticky error flags.
- read_rx_data, out, DATA_BITS: RX FIFO head (show-ahead).
- tx, out, 1: serial output, idle high.
- rx_empty / rx_full / tx_empty / tx_full, out, 1 each: FIFO status.
- rx_count / tx_count, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- tx_busy, out, 1: transmit frame in progress.
- frame_error / overrun / parity_error, out, 1 each: sticky error flags.

## Operation
**Oversample tick**
- DIV = (CLOCK_RATE + 8*BAUD_RATE) / (16*BAUD_RATE), clamped to ≥1.
- A counter produces a 1-cycle tick every DIV clocks (16× baud).
- One bit period is 16 ticks.

**FIFOs**
- Both FIFOs are show-ahead: read_rx_data is valid whenever rx_empty=0, and the pop strobe advances the head.
- A push when full is ignored, even if a pop occurs in the same cycle.
- A pop when empty is ignored.
- A simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

**RX path**
- rx passes through a 2-flop synchroniser.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: a synchronised low on a tick enters START.
- START: after 8 ticks, rx is sampled. High means a glitch: return to IDLE and store nothing.
- DATA: sample every 16 ticks, DATA_BITS samples, LSB first.
- STOP: sample after 16 ticks.
  - Sample 0: set frame_error and discard the word.
  - Sample 1 with RX FIFO full: set overrun and discard the word.
  - Otherwise push the word.
- A word with a parity error is still pushed, and parity_error is set.

**TX path**
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- On a tick in IDLE with enable=1 and tx_empty=0:
  - load the FIFO head into the shift register and pop the TX FIFO in the same cycle;
  - drive tx=0 and set tx_busy.
- Each bit lasts 16 ticks, LSB first.
- Stop bits last 16*STOP_BITS ticks. tx_busy clears on return to IDLE.

**enable=0**
- The RX FSM goes to IDLE immediately and discards any partial word.
- TX finishes the current frame, then does not start another.
- FIFOs, flags, and host pushes/pops still operate.

**Error flags and reset**
- Error flags are sticky until clear_errors=1 or reset.
- If an error event coincides with clear_errors, the flag ends set.
- reset mid-frame aborts immediately. tx returns to 1 on the next edge, and partial words are lost.

## Timing
- Reset values:
  - tx=1, tx_busy=0.
  - rx_empty=1, tx_empty=1, rx_full=0, tx_full=0.
  - rx_count=0, tx_count=0, read_rx_data=0.
  - frame_error=0, overrun=0, parity_error=0.
- Status outputs and counts are registered and update the cycle after the strobe edge.
- TX start latency from push: at most DIV+1 clocks to the falling start edge. The frame then lasts 16*(1+DATA_BITS+P+STOP_BITS) ticks, where P=1 with parity and 0 without.
- RX: the word is visible at the head (rx_empty=0) 1 clock after the stop-bit sample tick. Error flags assert on the same clock.
- Back-to-back TX: the next start bit follows the last stop bit with no idle gap if the FIFO is non-empty.

## Configuration
- UART_PARITY_EN defined:
  - one parity bit (even, or odd per PARITY_ODD) is inserted after the data bits on TX;
  - the parity bit is checked on RX, and a mismatch sets parity_error.
- Undefined:
  - no PARITY states;
  - parity_error tied 0;
  - PARITY_ODD ignored.

## Test plan
Bench parameters: CLOCK_RATE=1_600_000, BAUD_RATE=100_000 (DIV=1), DATA_BITS=8, FIFO_DEPTH=4.
- Loopback tx→rx, push 0xA5 → tx frame bits 0,1,0,1,0,0,1,0,1,1 at 16 clocks each; rx_empty falls; read_rx_data=0xA5.
- Push 5 words 0x01..0x05 with TX held (enable=0) → tx_full=1 after 4 pushes, tx_count=4, 0x05 dropped. Setting enable=1 transmits 0x01..0x04 back-to-back.
- Drive 5 frames into rx with no pops → rx_full=1, overrun=1, FIFO holds first 4. A clear_errors pulse clears overrun.
- Frame 0x3C with stop bit 0 → frame_error=1, rx_count stays 0.
- 4-clock low pulse on idle rx → no word, no flags, FSM back in IDLE.
- UART_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 → word 0x07 stored, parity_error=1. With parity bit 1 → parity_error stays 0.
